// File: rtl/button_conditioner.sv
// button_conditioner: N_BTN independent channels, each with a two-flop
// synchronizer, a stable-count debouncer, and registered one-cycle
// press/release pulses.
// Define BUTTON_AUTOREPEAT_EN to compile in auto-repeat press pulses while a
// button stays held. The default build has no repeat timer.
//
// Per-channel FSM
//   state        | meaning
//   ST_IDLE      | debounced level 0
//   ST_PRESSED   | debounced level 1, waiting REPEAT_DELAY for first repeat
//   ST_REPEATING | debounced level 1, pulsing every REPEAT_PERIOD
module button_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             CLK100MHZ,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int            RMAX       = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            TW         = $clog2(RMAX + 1);
  localparam logic [TW-1:0] TMR_DELAY  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] TMR_PERIOD = TW'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_REPEATING = 2'd2
  } state_e;

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD must be >= 1");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          sync1_q, sync2_q;
    logic          level_q, press_q, release_q;
    logic [CW-1:0] cnt_q;
    logic          accept_d;
    state_e        state_q;
`ifdef BUTTON_AUTOREPEAT_EN
    logic [TW-1:0] timer_q;
`endif

    // Two-flop synchronizer for the asynchronous raw level
    always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= btn_raw[i];
        sync2_q <= sync1_q;
      end
    end

    // New level is accepted on the edge that completes DEBOUNCE_CYCLES mismatches
    assign accept_d = (sync2_q != level_q) && (cnt_q == CNT_LAST);

    // Debounce counter: clears on agreement, flips the level on acceptance
    always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (accept_d) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    // Channel FSM with registered press/release pulses (release wins over a due repeat)
    always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
        state_q   <= ST_IDLE;
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
        timer_q   <= '0;
`endif
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (accept_d && sync2_q) begin
              press_q <= 1'b1;
              state_q <= ST_PRESSED;
`ifdef BUTTON_AUTOREPEAT_EN
              timer_q <= TMR_DELAY;
`endif
            end
          end
          ST_PRESSED, ST_REPEATING: begin
            if (accept_d && !sync2_q) begin
              release_q <= 1'b1;
              state_q   <= ST_IDLE;
            end
`ifdef BUTTON_AUTOREPEAT_EN
            else if (timer_q == '0) begin
              press_q <= 1'b1;
              state_q <= ST_REPEATING;
              timer_q <= TMR_PERIOD;
            end else begin
              timer_q <= timer_q - 1'b1;
            end
`endif
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3, N_BTN=5). The reference model decides acceptance from a
// window of recent raw samples and repeat pulses from the age of the press.
module tb_button_conditioner;
  localparam int N  = 5;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] lvl, pr, rl;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLK100MHZ(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(lvl), .btn_press(pr), .btn_release(rl)
  );

  typedef struct {int cyc; logic [N-1:0] lvl;} lvl_t;
  typedef struct {int cyc; logic [N-1:0] pr; logic [N-1:0] rl;} ev_t;
  lvl_t lvl_q[$];
  ev_t  ev_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state: hist[ch][0] is the newest raw sample
  bit [D:0]     hist[N];
  bit           m_lvl[N];
  int           age[N];
  int           edge_n = 0;
  logic [N-1:0] raw_v = '0;
  logic         rst_v = 1'b1;

  function automatic void model_edge();
    logic [N-1:0] epr, erl, el;
    lvl_t         le;
    ev_t          ee;
    epr = '0; erl = '0; el = '0;
    edge_n++;
    for (int ch = 0; ch < N; ch++) begin
      if (rst_v) begin
        hist[ch]  = '0;
        m_lvl[ch] = 1'b0;
        age[ch]   = 0;
      end else begin
        bit all_diff;
        all_diff = 1'b1;
        // samples seen by the debouncer: D consecutive ones behind the newest
        for (int k = 1; k <= D; k++)
          if (hist[ch][k] == m_lvl[ch]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[ch] = ~m_lvl[ch];
          age[ch]   = 0;
          if (m_lvl[ch]) epr[ch] = 1'b1;
          else           erl[ch] = 1'b1;
        end else if (m_lvl[ch]) begin
          age[ch]++;
`ifdef BUTTON_AUTOREPEAT_EN
          if (age[ch] == RD || (age[ch] > RD && (age[ch] - RD) % RP == 0))
            epr[ch] = 1'b1;
`endif
        end
        hist[ch] = {hist[ch][D-1:0], raw_v[ch]};
      end
      el[ch] = m_lvl[ch];
    end
    le.cyc = edge_n; le.lvl = el;
    lvl_q.push_back(le);
    if ((epr | erl) != '0) begin
      ee.cyc = edge_n; ee.pr = epr; ee.rl = erl;
      ev_q.push_back(ee);
    end
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      btn_raw = raw_v;
      rst     = rst_v;
      @(posedge clk);
      model_edge();
    end
  endtask

  // Monitor: checks level every cycle, pops an expected event whenever a pulse appears
  initial begin
    lvl_t cur;
    ev_t  e;
    forever begin
      @(negedge clk);
      if (lvl_q.size() == 0) continue;
      cur = lvl_q.pop_front();
      total++;
      if (lvl !== cur.lvl) begin
        bad++;
        $display("FAIL level edge=%0d got=%b exp=%b", cur.cyc, lvl, cur.lvl);
      end
      if ((pr | rl) !== '0) begin
        total++;
        if ((pr & rl) !== '0) begin
          bad++;
          $display("FAIL overlap edge=%0d press=%b release=%b", cur.cyc, pr, rl);
        end
        total++;
        if (ev_q.size() > 0 && ev_q[0].cyc == cur.cyc) begin
          e = ev_q.pop_front();
          if (pr !== e.pr || rl !== e.rl) begin
            bad++;
            $display("FAIL pulse edge=%0d got press=%b release=%b exp press=%b release=%b",
                     cur.cyc, pr, rl, e.pr, e.rl);
          end
        end else begin
          bad++;
          $display("FAIL unexpected edge=%0d got press=%b release=%b exp none", cur.cyc, pr, rl);
        end
      end
      while (ev_q.size() > 0 && ev_q[0].cyc <= cur.cyc) begin
        e = ev_q.pop_front();
        total++;
        bad++;
        $display("FAIL missing edge=%0d got none exp press=%b release=%b", e.cyc, e.pr, e.rl);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    rst_v = 1'b1; raw_v = '0;
    step(3);
    rst_v = 1'b0;
    step(2);
    // clean press on channel 0
    raw_v[0] = 1'b1; step(12);
    raw_v[0] = 1'b0; step(12);
    // bounce on channel 1 never long enough to accept
    raw_v[1] = 1'b1; step(3);
    raw_v[1] = 1'b0; step(1);
    raw_v[1] = 1'b1; step(3);
    raw_v[1] = 1'b0; step(10);
    // press/release on channel 2
    raw_v[2] = 1'b1; step(20);
    raw_v[2] = 1'b0; step(20);
    // reset while channel 3 is held and accepted
    raw_v[3] = 1'b1; step(10);
    rst_v = 1'b1; step(1);
    rst_v = 1'b0; step(12);
    raw_v[3] = 1'b0; step(10);
    // long hold on channel 4 (auto-repeat when compiled in)
    raw_v[4] = 1'b1; step(30);
    raw_v[4] = 1'b0; step(15);
    // fast random bouncing on all channels, occasional reset
    for (int c = 0; c < 2500; c++) begin
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, 5) == 0) raw_v[ch] = ~raw_v[ch];
      rst_v = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst_v = 1'b0;
    // slower random holds to exercise long presses
    for (int c = 0; c < 2000; c++) begin
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, 39) == 0) raw_v[ch] = ~raw_v[ch];
      step(1);
    end
    raw_v = '0;
    step(12);
    @(negedge clk);
    #1;
    total++;
    if (ev_q.size() != 0) begin
      bad++;
      $display("FAIL leftover got %0d pending events exp 0", ev_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
